qsys_10g_avst_ready_latency_adapter: RTL and testbench

//  Parametrised Avalon-ST timing adapter for the 10G packet-generator/checker path.

---
 rtl/qsys_10g_avst_ready_latency_adapter.sv | 107 ++++++++++
 tb/tb_qsys_10g_avst_ready_latency_adapter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qsys_10g_avst_ready_latency_adapter.sv
// Avalon-ST ready-latency adapter for the 10G packet generator/checker path.
// Takes a ready-latency-0 stream into a small register FIFO and presents it to
// a sink whose ready has OUT_READY_LATENCY cycles of latency. Also counts cycles
// where the sink had a slot open but the FIFO was empty.
module qsys_10g_avst_ready_latency_adapter #(
  parameter int DATA_W            = 2,
  parameter int DEPTH             = 4,
  parameter int OUT_READY_LATENCY = 0,
  parameter int CNT_W             = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [CNT_W-1:0]         starve_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  fill_next;
  logic              slot;
  logic              wr_en;
  logic              rd_en;

  generate
    if (OUT_READY_LATENCY == 0) begin : g_rl0
      // With zero latency the sink's ready is itself the transfer slot.
      assign slot = out_ready;
    end else begin : g_rln
      logic [OUT_READY_LATENCY-1:0] rdy_dly;

      // Delay out_ready so the slot lines up with the cycle the sink committed to.
      always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!reset_n) begin
          rdy_dly <= '0;
        end else begin
          rdy_dly <= (rdy_dly << 1) | OUT_READY_LATENCY'(out_ready);
        end
      end

      assign slot = rdy_dly[OUT_READY_LATENCY-1];
    end
  endgenerate

  // A slot is only used when there is something buffered, so out_valid never
  // rises outside a slot the sink granted.
  assign wr_en     = in_valid & in_ready;
  assign out_valid = slot & (fill_level != '0);
  assign rd_en     = out_valid;
  assign out_data  = mem[rd_ptr];

  // Next occupancy: a simultaneous write and read leaves the level unchanged.
  always_comb begin
    // NOTE: default assigned first so every path drives fill_next and no latch is inferred.
    fill_next = fill_level;
    if (wr_en && !rd_en) begin
      fill_next = fill_level + LVL_W'(1);
    end else if (!wr_en && rd_en) begin
      fill_next = fill_level - LVL_W'(1);
    end
  end

  // Pointers, occupancy and registered in_ready (no combinational out_ready->in_ready path).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      in_ready   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      fill_level <= fill_next;
      in_ready   <= (fill_next < LVL_W'(DEPTH));
    end
  end

  // Payload storage; the head entry drives out_data directly from registers.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; resetting the pointers
    // and level is enough to make stale entries unreachable.
    if (reset_n && wr_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Saturating count of slots that went unused because the FIFO was empty.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (slot && (fill_level == '0) && (starve_cnt != '1)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_qsys_10g_avst_ready_latency_adapter.sv
// Bench for the ready-latency adapter: one RL=0 instance and one RL=2 instance
// with a 4-bit starve counter, each with its own scoreboard queue.
module tb_qsys_10g_avst_ready_latency_adapter;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;

  logic          in_ready0, in_valid0, out_ready0, out_valid0;
  logic [DW-1:0] in_data0, out_data0;
  logic [2:0]    fill0;
  logic [15:0]   starve0;

  logic          in_ready2, in_valid2, out_ready2, out_valid2;
  logic [DW-1:0] in_data2, out_data2;
  logic [2:0]    fill2;
  logic [3:0]    starve2;

  int total = 0;
  int bad   = 0;
  int out_cnt0 = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q2[$];

  always #5 clk = ~clk;

  qsys_10g_avst_ready_latency_adapter #(
    .DATA_W(DW), .DEPTH(4), .OUT_READY_LATENCY(0), .CNT_W(16)
  ) u_rl0 (
    .clk(clk), .reset_n(reset_n),
    .in_ready(in_ready0), .in_valid(in_valid0), .in_data(in_data0),
    .out_ready(out_ready0), .out_valid(out_valid0), .out_data(out_data0),
    .fill_level(fill0), .starve_cnt(starve0)
  );

  qsys_10g_avst_ready_latency_adapter #(
    .DATA_W(DW), .DEPTH(4), .OUT_READY_LATENCY(2), .CNT_W(4)
  ) u_rl2 (
    .clk(clk), .reset_n(reset_n),
    .in_ready(in_ready2), .in_valid(in_valid2), .in_data(in_data2),
    .out_ready(out_ready2), .out_valid(out_valid2), .out_data(out_data2),
    .fill_level(fill2), .starve_cnt(starve2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboards: pop-and-compare on each output transfer, push on each accepted beat.
  always @(negedge clk) begin
    if (!reset_n) begin
      q0.delete();
      out_cnt0 = 0;
    end else begin
      if (out_valid0) begin
        out_cnt0++;
        if (q0.size() == 0) check("sb0_unexpected_valid", 32'(out_valid0), 32'd0);
        else                check("sb0_data", 32'(out_data0), 32'(q0.pop_front()));
      end
      if (in_valid0 && in_ready0) q0.push_back(in_data0);
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      q2.delete();
    end else begin
      if (out_valid2) begin
        if (q2.size() == 0) check("sb2_unexpected_valid", 32'(out_valid2), 32'd0);
        else                check("sb2_data", 32'(out_data2), 32'(q2.pop_front()));
      end
      if (in_valid2 && in_ready2) q2.push_back(in_data2);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit or_pat [10] = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    bit ov_exp [10] = '{0, 0, 1, 0, 1, 1, 0, 0, 0, 0};
    int acc;
    int n;
    logic take;

    // Reset held for three edges with upstream valid asserted.
    reset_n    = 1'b0;
    in_valid0  = 1'b1; in_data0 = '0; out_ready0 = 1'b0;
    in_valid2  = 1'b1; in_data2 = '0; out_ready2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready0",  32'(in_ready0),  32'd0);
    check("rst_out_valid0", 32'(out_valid0), 32'd0);
    check("rst_fill0",      32'(fill0),      32'd0);
    check("rst_starve0",    32'(starve0),    32'd0);
    check("rst_in_ready2",  32'(in_ready2),  32'd0);
    check("rst_out_valid2", 32'(out_valid2), 32'd0);
    reset_n   = 1'b1;
    in_valid0 = 1'b0;
    in_valid2 = 1'b0;
    align();
    @(negedge clk);
    check("post_rst_in_ready0", 32'(in_ready0), 32'd1);
    check("post_rst_in_ready2", 32'(in_ready2), 32'd1);

    // RL=0 stream: two idle slots, then four back-to-back beats.
    out_ready0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      in_valid0 = 1'b1;
      in_data0  = DW'(8'h10 + i);
      @(negedge clk);
      check("strm_in_ready",  32'(in_ready0),  32'd1);
      check("strm_fill",      32'(fill0),      (i == 0) ? 32'd0 : 32'd1);
      check("strm_out_valid", 32'(out_valid0), (i == 0) ? 32'd0 : 32'd1);
      align();
    end
    in_valid0 = 1'b0;
    @(negedge clk);
    check("strm_last_valid", 32'(out_valid0), 32'd1);
    align();
    out_ready0 = 1'b0;
    @(negedge clk);
    check("strm_fill_end",   32'(fill0),      32'd0);
    check("strm_starve",     32'(starve0),    32'd3);
    check("strm_valid_end",  32'(out_valid0), 32'd0);

    // Full: six beats offered against a stalled sink.
    align();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid0 = 1'b1;
      in_data0  = DW'(8'h20 + acc);
      @(negedge clk);
      take = in_ready0;
      check("full_in_ready", 32'(in_ready0), (i < 4) ? 32'd1 : 32'd0);
      check("full_fill",     32'(fill0),     (i < 4) ? 32'(i) : 32'd4);
      align();
      if (take) acc++;
    end
    @(negedge clk);
    check("full_fill4",    32'(fill0),     32'd4);
    check("full_blocked",  32'(in_ready0), 32'd0);
    check("full_accepted", 32'(acc),       32'd4);
    out_ready0 = 1'b1;
    align();
    @(negedge clk);
    check("full_ready_back", 32'(in_ready0), 32'd1);
    check("full_fill3",      32'(fill0),     32'd3);
    align();
    in_valid0 = 1'b0;
    n = 0;
    while (fill0 != 3'd0 && n < 10) begin
      align();
      n++;
    end
    check("full_drained", 32'(fill0), 32'd0);
    @(negedge clk);
    check("full_sb_empty", 32'(q0.size()), 32'd0);
    out_ready0 = 1'b0;

    // RL=2: preload three beats, then a ready pattern; valid follows two cycles later.
    align();
    for (int i = 0; i < 3; i++) begin
      in_valid2 = 1'b1;
      in_data2  = DW'(8'h30 + i);
      @(negedge clk);
      check("rl2_pre_in_ready", 32'(in_ready2), 32'd1);
      align();
    end
    in_valid2 = 1'b0;
    @(negedge clk);
    check("rl2_pre_fill",  32'(fill2),      32'd3);
    check("rl2_pre_valid", 32'(out_valid2), 32'd0);
    for (int k = 0; k < 10; k++) begin
      out_ready2 = or_pat[k];
      #1;
      check($sformatf("rl2_valid_c%0d", k), 32'(out_valid2), 32'(ov_exp[k]));
      @(negedge clk);
    end
    check("rl2_fill_end",   32'(fill2),   32'd0);
    check("rl2_starve_end", 32'(starve2), 32'd0);

    // Starve saturation on the 4-bit counter: 20 cycles of ready with nothing buffered.
    out_ready2 = 1'b1;
    repeat (10) @(negedge clk);
    check("sat_mid", 32'(starve2), 32'd8);
    repeat (10) @(negedge clk);
    out_ready2 = 1'b0;
    repeat (3) @(negedge clk);
    check("sat_final", 32'(starve2), 32'd15);

    // Reset mid-operation with three beats buffered.
    align();
    for (int i = 0; i < 3; i++) begin
      in_valid0 = 1'b1;
      in_data0  = DW'(8'hA0 + i);
      @(negedge clk);
      check("mid_pre_in_ready", 32'(in_ready0), 32'd1);
      align();
    end
    in_valid0 = 1'b0;
    @(negedge clk);
    check("mid_pre_fill", 32'(fill0), 32'd3);
    reset_n    = 1'b0;
    out_ready0 = 1'b1;
    align();
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_fill",      32'(fill0),      32'd0);
    check("mid_out_valid", 32'(out_valid0), 32'd0);
    check("mid_in_ready",  32'(in_ready0),  32'd0);
    check("mid_starve2",   32'(starve2),    32'd0);
    align();
    for (int i = 0; i < 2; i++) begin
      in_valid0 = 1'b1;
      in_data0  = DW'(8'h55 + i);
      @(negedge clk);
      check("mid_new_in_ready", 32'(in_ready0), 32'd1);
      align();
    end
    in_valid0 = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_out_count", 32'(out_cnt0),   32'd2);
    check("mid_sb_empty",  32'(q0.size()),  32'd0);
    check("mid_fill_end",  32'(fill0),      32'd0);
    check("sb2_empty_end", 32'(q2.size()),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
